memory_stage: RTL and testbench

- Memory stage directly downstream of the execute stage in the LEGv8 datapath.
- Registers the execute results (EX/MEM boundary) and resolves the conditional branch (PCSrc).
- Performs data-memory loads and stores over a req/ready handshake, with a wait-state counter and timeout.
- Stalls upstream while an access is in flight and presents registered results to writeback.

---
 rtl/memory_stage.sv | 214 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// LEGv8 memory stage: EX/MEM pipeline register, CBZ resolution, and a
// req/ready data-memory port with a wait-state counter and timeout abort.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | no access in flight; stage accepts a new instruction when valid_E
//   ACCESS | memory op in flight; dm_req held, upstream stalled until dm_ready
//          | arrives or the wait counter exhausts WAIT_LIMIT cycles
module memory_stage #(
    parameter int N          = 64,
    parameter int WAIT_LIMIT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         Branch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         RegWrite_E,
    input  logic         MemtoReg_E,
    input  logic [4:0]   Rd_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ready,
    input  logic [N-1:0] dm_rdata,
    output logic         mem_fault,
    output logic         valid_W,
    output logic         RegWrite_W,
    output logic         MemtoReg_W,
    output logic [4:0]   Rd_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W
);

    // Counter only has to reach WAIT_LIMIT-1: the abort happens on the edge
    // that would make it WAIT_LIMIT.
    localparam int                CNT_W     = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             accept;
    logic             mem_op_E;
    logic             done;
    logic             timeout;

    // EX/MEM stage registers held for the duration of a memory access
    logic             mem_read_q;
    logic             mem_write_q;
    logic             reg_write_q;
    logic             memto_reg_q;
    logic [4:0]       rd_q;
    logic [N-1:0]     alu_q;
    logic [N-1:0]     wdata_q;

    assign mem_op_E = MemRead_E | MemWrite_E;

    // State register and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
        end
    end

    // Next-state logic, transaction events and Moore handshake outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        accept    = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        stall_M   = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        case (state)
            IDLE: begin
                if (valid_E) begin
                    accept = 1'b1;
                    if (mem_op_E) begin
                        state_nxt = ACCESS;
                        cnt_nxt   = '0;
                    end
                end
            end
            ACCESS: begin
                stall_M = 1'b1;
                dm_req  = 1'b1;
                // Both read and write set is treated as a write
                dm_we   = mem_write_q;
                if (dm_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address and write data come straight from the stage registers, which
    // only change on an accept, so they stay stable while dm_req is high.
    assign dm_addr  = alu_q;
    assign dm_wdata = wdata_q;

    // Capture of execute results on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
            rd_q        <= '0;
            alu_q       <= '0;
            wdata_q     <= '0;
        end else if (accept) begin
            mem_read_q  <= MemRead_E;
            mem_write_q <= MemWrite_E;
            reg_write_q <= RegWrite_E;
            memto_reg_q <= MemtoReg_E;
            rd_q        <= Rd_E;
            alu_q       <= aluResult_E;
            wdata_q     <= writeData_E;
        end
    end

    // Branch resolution: PCSrc is a single-cycle pulse after the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            PCSrc_M    <= 1'b0;
            PCBranch_M <= '0;
        end else begin
            PCSrc_M <= accept & Branch_E & zero_E;
            if (accept) begin
                PCBranch_M <= PCBranch_E;
            end
        end
    end

    // Writeback outputs: valid_W and RegWrite_W pulse, the rest hold between results
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_W     <= 1'b0;
            RegWrite_W  <= 1'b0;
            MemtoReg_W  <= 1'b0;
            Rd_W        <= '0;
            aluResult_W <= '0;
            readData_W  <= '0;
        end else begin
            valid_W    <= 1'b0;
            RegWrite_W <= 1'b0;
            if (accept && !mem_op_E) begin
                valid_W     <= 1'b1;
                RegWrite_W  <= RegWrite_E;
                MemtoReg_W  <= MemtoReg_E;
                Rd_W        <= Rd_E;
                aluResult_W <= aluResult_E;
                readData_W  <= '0;
            end else if (done) begin
                valid_W     <= 1'b1;
                RegWrite_W  <= reg_write_q;
                MemtoReg_W  <= memto_reg_q;
                Rd_W        <= rd_q;
                aluResult_W <= alu_q;
                readData_W  <= (mem_read_q && !mem_write_q) ? dm_rdata : '0;
            end else if (timeout) begin
                // Aborted access still retires so the pipeline drains, but
                // it must not write the register file.
                valid_W     <= 1'b1;
                RegWrite_W  <= 1'b0;
                MemtoReg_W  <= memto_reg_q;
                Rd_W        <= rd_q;
                aluResult_W <= alu_q;
                readData_W  <= '0;
            end
        end
    end

    // Sticky fault flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_fault <= 1'b0;
        end else if (timeout) begin
            mem_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table vectors, directed corner
// sequences and randomized transactions against a transaction-level model.
module tb_memory_stage;

    localparam int N  = 64;
    localparam int WL = 4;

    logic         clk;
    logic         reset;
    logic         valid_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
    logic [4:0]   Rd_E;
    logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
    logic         zero_E;
    logic         stall_M, PCSrc_M;
    logic [N-1:0] PCBranch_M;
    logic         dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata;
    logic         dm_ready;
    logic [N-1:0] dm_rdata;
    logic         mem_fault, valid_W, RegWrite_W, MemtoReg_W;
    logic [4:0]   Rd_W;
    logic [N-1:0] aluResult_W, readData_W;

    int tests;
    int fails;
    logic model_fault;

    memory_stage #(.N(N), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset),
        .valid_E(valid_E), .Branch_E(Branch_E), .MemRead_E(MemRead_E),
        .MemWrite_E(MemWrite_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
        .Rd_E(Rd_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
        .PCBranch_E(PCBranch_E), .zero_E(zero_E),
        .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_fault(mem_fault), .valid_W(valid_W), .RegWrite_W(RegWrite_W),
        .MemtoReg_W(MemtoReg_W), .Rd_W(Rd_W), .aluResult_W(aluResult_W),
        .readData_W(readData_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_E     = 1'b0;
        Branch_E    = 1'b0;
        MemRead_E   = 1'b0;
        MemWrite_E  = 1'b0;
        RegWrite_E  = 1'b0;
        MemtoReg_E  = 1'b0;
        Rd_E        = '0;
        aluResult_E = '0;
        writeData_E = '0;
        PCBranch_E  = '0;
        zero_E      = 1'b0;
        dm_ready    = 1'b0;
        dm_rdata    = '0;
    endtask

    // One instruction from IDLE through retirement. lat = number of ACCESS
    // cycles the memory leaves dm_ready low before completing; lat >= WL means
    // the memory never answers in time.
    task automatic run_op(input logic rd_f, input logic wr_f, input logic rw,
                          input logic m2r, input logic [4:0] rd,
                          input logic [N-1:0] alu, input logic [N-1:0] wdata,
                          input logic [N-1:0] pcb, input int lat,
                          input logic [N-1:0] rdata);
        logic       is_mem;
        logic       timed_out;
        int         acc_len;
        logic       exp_rw;
        logic [N-1:0] exp_rd_data;
        int         n;

        is_mem      = rd_f | wr_f;
        timed_out   = is_mem && (lat >= WL);
        acc_len     = !is_mem ? 0 : (timed_out ? WL : lat + 1);
        exp_rw      = timed_out ? 1'b0 : rw;
        exp_rd_data = (is_mem && !timed_out && rd_f && !wr_f) ? rdata : '0;
        if (timed_out) model_fault = 1'b1;

        valid_E     = 1'b1;
        Branch_E    = 1'b0;
        MemRead_E   = rd_f;
        MemWrite_E  = wr_f;
        RegWrite_E  = rw;
        MemtoReg_E  = m2r;
        Rd_E        = rd;
        aluResult_E = alu;
        writeData_E = wdata;
        PCBranch_E  = pcb;
        zero_E      = $urandom_range(0, 1);
        dm_ready    = 1'b0;
        tick();
        chk("PCSrc_nobranch", PCSrc_M, 0);
        chk("PCBranch_M", PCBranch_M, pcb);

        n = 0;
        if (is_mem) begin
            // Garbage on the execute side while stalled must be ignored
            while (n < 40) begin
                MemRead_E   = $urandom_range(0, 1);
                MemWrite_E  = $urandom_range(0, 1);
                Branch_E    = $urandom_range(0, 1);
                zero_E      = $urandom_range(0, 1);
                RegWrite_E  = $urandom_range(0, 1);
                Rd_E        = 5'($urandom);
                aluResult_E = {$urandom, $urandom};
                writeData_E = {$urandom, $urandom};
                chk("dm_req_access", dm_req, 1);
                chk("stall_access", stall_M, 1);
                chk("dm_addr", dm_addr, alu);
                chk("dm_wdata", dm_wdata, wdata);
                chk("dm_we", dm_we, wr_f);
                dm_ready = (n == lat);
                dm_rdata = (n == lat) ? rdata : {$urandom, $urandom};
                tick();
                n++;
                if (valid_W === 1'b1) break;
            end
            valid_E  = 1'b0;
            dm_ready = 1'b0;
            chk("access_len", N'(n), N'(acc_len));
        end

        chk("valid_W", valid_W, 1);
        chk("stall_after", stall_M, 0);
        chk("dm_req_after", dm_req, 0);
        chk("RegWrite_W", RegWrite_W, exp_rw);
        chk("MemtoReg_W", MemtoReg_W, m2r);
        chk("Rd_W", Rd_W, rd);
        chk("aluResult_W", aluResult_W, alu);
        chk("readData_W", readData_W, exp_rd_data);
        chk("mem_fault", mem_fault, model_fault);

        idle_inputs();
        tick();
        chk("valid_W_pulse", valid_W, 0);
        chk("RegWrite_W_idle", RegWrite_W, 0);
        chk("Rd_W_hold", Rd_W, rd);
    endtask

    typedef struct {
        logic         valid;
        logic         br;
        logic         zero;
        logic         rw;
        logic [4:0]   rd;
        logic [N-1:0] alu;
        logic [N-1:0] pcb;
        logic         e_valid_w;
        logic         e_rw_w;
        logic         e_pcsrc;
        logic [4:0]   e_rd;
        logic [N-1:0] e_alu;
        logic [N-1:0] e_pcb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        tests       = 0;
        fails       = 0;
        model_fault = 1'b0;
        reset       = 1'b1;
        idle_inputs();

        // Single-cycle (non-memory) ops from IDLE
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  64'h2A, 64'h0,
                    1'b1, 1'b1, 1'b0, 5'd5,  64'h2A, 64'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  64'h0,  64'h400,
                    1'b1, 1'b0, 1'b1, 5'd0,  64'h0,  64'h400};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  64'h7,  64'h800,
                    1'b1, 1'b0, 1'b0, 5'd0,  64'h7,  64'h800};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  64'hFFFF, 64'h123,
                    1'b0, 1'b0, 1'b0, 5'd0,  64'h7,  64'h800};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                    1'b1, 1'b1, 1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd3,  64'h10, 64'hABC0,
                    1'b1, 1'b0, 1'b1, 5'd3,  64'h10, 64'hABC0};

        tick();
        chk("rst_stall", stall_M, 0);
        chk("rst_dm_req", dm_req, 0);
        chk("rst_valid_W", valid_W, 0);
        chk("rst_mem_fault", mem_fault, 0);
        chk("rst_PCSrc", PCSrc_M, 0);
        chk("rst_aluResult_W", aluResult_W, 0);
        chk("rst_dm_addr", dm_addr, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            valid_E     = vecs[i].valid;
            Branch_E    = vecs[i].br;
            zero_E      = vecs[i].zero;
            RegWrite_E  = vecs[i].rw;
            Rd_E        = vecs[i].rd;
            aluResult_E = vecs[i].alu;
            PCBranch_E  = vecs[i].pcb;
            tick();
            chk("vec_valid_W", valid_W, vecs[i].e_valid_w);
            chk("vec_RegWrite_W", RegWrite_W, vecs[i].e_rw_w);
            chk("vec_PCSrc_M", PCSrc_M, vecs[i].e_pcsrc);
            chk("vec_Rd_W", Rd_W, vecs[i].e_rd);
            chk("vec_aluResult_W", aluResult_W, vecs[i].e_alu);
            chk("vec_PCBranch_M", PCBranch_M, vecs[i].e_pcb);
            chk("vec_stall", stall_M, 0);
            chk("vec_readData_W", readData_W, 0);
        end
        idle_inputs();
        tick();
        chk("pcsrc_one_cycle", PCSrc_M, 0);

        // Load, three wait cycles then ready
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 64'h100, 64'h0, 64'h0, 3, 64'hDEADBEEF);
        // Store, immediate ready
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h80, 64'h55, 64'h0, 0, 64'h1234);
        // Read and write both set behaves as a write
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 64'h88, 64'h66, 64'h0, 1, 64'h9999);
        // Ready on the very last allowed cycle still completes
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 64'h90, 64'h0, 64'h0, WL - 1, 64'hCAFE);
        // Memory never answers: abort after WL cycles, fault sticks
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 64'h200, 64'h0, 64'h0, 1000, 64'h0);
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 64'h33, 64'h0, 64'h0, 0, 64'h0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 64'h208, 64'h0, 64'h0, 2, 64'h77);

        // Reset in the second ACCESS cycle abandons the access
        valid_E     = 1'b1;
        MemRead_E   = 1'b1;
        RegWrite_E  = 1'b1;
        Rd_E        = 5'd11;
        aluResult_E = 64'h300;
        tick();
        idle_inputs();
        tick();
        chk("acc2_dm_req", dm_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_fault = 1'b0;
        chk("rst_acc_dm_req", dm_req, 0);
        chk("rst_acc_stall", stall_M, 0);
        chk("rst_acc_valid_W", valid_W, 0);
        chk("rst_acc_mem_fault", mem_fault, 0);
        dm_ready = 1'b1;
        dm_rdata = 64'hBAD;
        tick();
        chk("late_ready_valid_W", valid_W, 0);
        chk("late_ready_dm_req", dm_req, 0);
        chk("late_ready_readData", readData_W, 0);
        idle_inputs();
        tick();

        // Randomized transactions
        for (int k = 0; k < 150; k++) begin
            int          kind;
            logic        rd_f, wr_f, rw;
            kind = $urandom_range(0, 3);
            rd_f = (kind == 1) || (kind == 3);
            wr_f = (kind == 2) || (kind == 3);
            rw   = wr_f ? 1'b0 : 1'($urandom_range(0, 1));
            run_op(rd_f, wr_f, rw, 1'($urandom_range(0, 1)), 5'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, WL + 1), {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
